wb_scheduler: RTL and testbench

Write-port scheduler for the 32x32 register file. It merges single-cycle ALU results and multi-cycle 64-bit multiply results onto the file's single write port (`RW_1`/`MD_1`/`DA_1`/`D_DATA`). It sits between execute and the write-back (WB) phase. It also keeps a scoreboard of destination registers with a multiply in flight, so operand fetch can stall on RAW hazards.

---
 rtl/wb_scheduler.sv | 179 +++++++++++++++++
 tb/tb_wb_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scheduler.sv
// Write-port scheduler: merges ALU results and multi-cycle 64-bit multiply results onto one register-file write port.
// Optional RAW scoreboard and hazard output are enabled by defining WB_SCOREBOARD_EN.
module wb_scheduler #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_da,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        mul_start,
    input  logic [4:0]  mul_da,
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    output logic        mul_busy,
    input  logic [4:0]  aa,
    input  logic [4:0]  ba,
    output logic        hazard,
    output logic        RW_1,
    output logic [1:0]  MD_1,
    output logic [4:0]  DA_1,
    output logic [63:0] D_DATA
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [63:0] prod_r;
    logic [4:0]  mda_r;
    logic        issue_s;
    logic        wr_en_s;
    logic [1:0]  wr_md_s;
    logic [4:0]  wr_da_s;
    logic [63:0] wr_data_s;

    // Multiply state register, latency counter and latched operands
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            prod_r  <= 64'd0;
            mda_r   <= 5'd0;
        end else begin
            state_r <= state_s;
            if (issue_s) begin
                prod_r <= {32'd0, mul_a} * {32'd0, mul_b};
                mda_r  <= mul_da;
                cnt_r  <= LAT_M1;
            end else if (state_r == ST_BUSY) begin
                cnt_r  <= cnt_r - 4'd1;
            end else begin
                cnt_r  <= cnt_r;
            end
        end
    end

    // Next-state logic; BUSY leaves when the decremented count reaches zero
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mul_start) begin
                    state_s = (MUL_LAT == 1) ? ST_DONE : ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r <= 4'd1) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Status outputs and write-port selection (multiply wins in DONE)
    always_comb begin
        issue_s   = (state_r == ST_IDLE) & mul_start;
        mul_busy  = (state_r != ST_IDLE);
        alu_stall = alu_valid & (state_r == ST_DONE);
        wr_en_s   = 1'b0;
        wr_md_s   = 2'b00;
        wr_da_s   = DA_1;
        wr_data_s = D_DATA;
        if (state_r == ST_DONE) begin
            wr_en_s = 1'b1;
            wr_da_s = mda_r;
            // R31 pair would wrap onto R0, so only the low word is written
            if (mda_r == 5'd31) begin
                wr_md_s   = 2'b00;
                wr_data_s = {32'd0, prod_r[31:0]};
            end else begin
                wr_md_s   = 2'b11;
                wr_data_s = prod_r;
            end
        end else if (alu_valid) begin
            wr_en_s   = 1'b1;
            wr_da_s   = alu_da;
            wr_data_s = {32'd0, alu_data};
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            RW_1   <= 1'b0;
            MD_1   <= 2'b00;
            DA_1   <= 5'd0;
            D_DATA <= 64'd0;
        end else begin
            RW_1   <= wr_en_s;
            MD_1   <= wr_md_s;
            DA_1   <= wr_da_s;
            D_DATA <= wr_data_s;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] sb_r;
    logic [31:0] set_s;
    logic [31:0] clr_s;
    logic [4:0]  set_hi_s;
    logic [4:0]  clr_hi_s;

    // Scoreboard set/clear masks; bit 0 is masked because R0 is never a real destination
    always_comb begin
        set_s    = 32'd0;
        clr_s    = 32'd0;
        set_hi_s = mul_da + 5'd1;
        clr_hi_s = mda_r + 5'd1;
        if (issue_s) begin
            set_s[mul_da] = 1'b1;
            if (mul_da != 5'd31) begin
                set_s[set_hi_s] = 1'b1;
            end else begin
                set_s[set_hi_s] = 1'b0;
            end
        end else begin
            set_s = 32'd0;
        end
        set_s[0] = 1'b0;
        if (state_r == ST_DONE) begin
            clr_s[mda_r]    = 1'b1;
            clr_s[clr_hi_s] = 1'b1;
        end else begin
            clr_s = 32'd0;
        end
    end

    // Busy-destination vector
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_r <= 32'd0;
        end else begin
            sb_r <= (sb_r & ~clr_s) | set_s;
        end
    end

    assign hazard = sb_r[aa] | sb_r[ba];
`else
    assign hazard = &{1'b0, aa, ba};
`endif

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_wb_scheduler;

    localparam int LAT = 4;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_da = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        alu_stall;
    logic        mul_start = 1'b0;
    logic [4:0]  mul_da = 5'd0;
    logic [31:0] mul_a = 32'd0;
    logic [31:0] mul_b = 32'd0;
    logic        mul_busy;
    logic [4:0]  aa = 5'd0;
    logic [4:0]  ba = 5'd0;
    logic        hazard;
    logic        RW_1;
    logic [1:0]  MD_1;
    logic [4:0]  DA_1;
    logic [63:0] D_DATA;

    int total = 0;
    int bad = 0;

    wb_scheduler #(.MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_da(alu_da), .alu_data(alu_data), .alu_stall(alu_stall),
        .mul_start(mul_start), .mul_da(mul_da), .mul_a(mul_a), .mul_b(mul_b), .mul_busy(mul_busy),
        .aa(aa), .ba(ba), .hazard(hazard),
        .RW_1(RW_1), .MD_1(MD_1), .DA_1(DA_1), .D_DATA(D_DATA)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding multiply described by its issue cycle
    int          cyc = 0;
    bit          m_act = 1'b0;
    int          m_iss = 0;
    logic [63:0] m_prod = 64'd0;
    logic [4:0]  m_da = 5'd0;
    logic        e_rw = 1'b0;
    logic [1:0]  e_md = 2'b00;
    logic [4:0]  e_da = 5'd0;
    logic [63:0] e_data = 64'd0;
    logic        e_busy, e_done, e_stall, e_haz;

    function automatic bit hit(input logic [4:0] r);
        return (r != 5'd0) && ((r == m_da) || ((m_da != 5'd31) && (r == m_da + 5'd1)));
    endfunction

    task automatic settle();
        #3;
        e_busy  = m_act && (cyc > m_iss) && (cyc <= m_iss + LAT);
        e_done  = m_act && (cyc == m_iss + LAT);
        e_stall = alu_valid && e_done;
        e_haz   = SB_EN && e_busy && (hit(aa) || hit(ba));
    endtask

    task automatic advance();
        if (rst) begin
            e_rw = 1'b0; e_md = 2'b00; e_da = 5'd0; e_data = 64'd0; m_act = 1'b0;
        end else begin
            if (e_done) begin
                e_rw = 1'b1; e_da = m_da;
                if (m_da == 5'd31) begin
                    e_md = 2'b00; e_data = {32'd0, m_prod[31:0]};
                end else begin
                    e_md = 2'b11; e_data = m_prod;
                end
                m_act = 1'b0;
            end else if (alu_valid) begin
                e_rw = 1'b1; e_md = 2'b00; e_da = alu_da; e_data = {32'd0, alu_data};
            end else begin
                e_rw = 1'b0; e_md = 2'b00;
            end
            if (mul_start && !e_busy) begin
                m_act = 1'b1; m_iss = cyc; m_da = mul_da;
                m_prod = 64'(mul_a) * 64'(mul_b);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_valid = 1'b1; alu_da = 5'd7; alu_data = 32'hdead;
        for (int i = 0; i < 2; i++) begin
            settle(); advance();
        end
        rst = 1'b0; alu_valid = 1'b1; alu_da = 5'd5; alu_data = 32'h1234;
        settle();
        total++; if ({RW_1, MD_1, DA_1} !== 8'd0) begin bad++; $display("FAIL reset_port: got %b_%b_%0d want 0", RW_1, MD_1, DA_1); end
        total++; if (D_DATA !== 64'd0) begin bad++; $display("FAIL reset_data: got %0h want 0", D_DATA); end
        total++; if ({mul_busy, alu_stall, hazard} !== 3'b000) begin bad++; $display("FAIL reset_status: got %b want 000", {mul_busy, alu_stall, hazard}); end
        advance();
        alu_valid = 1'b0;
        settle();
        total++; if ({RW_1, MD_1, DA_1} !== {1'b1, 2'b00, 5'd5}) begin bad++; $display("FAIL reset_alu_port: got %b_%b_%0d want 1_00_5", RW_1, MD_1, DA_1); end
        total++; if (D_DATA !== 64'h1234) begin bad++; $display("FAIL reset_alu_data: got %0h want 1234", D_DATA); end
        advance();
    endtask

    task automatic test_multiply();
        int busy_cnt = 0;
        mul_start = 1'b1; mul_da = 5'd6; mul_a = 32'hFFFFFFFF; mul_b = 32'd2;
        settle(); advance();
        mul_start = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            settle();
            if (mul_busy === 1'b1) busy_cnt++;
            total++; if (RW_1 !== (k == LAT + 1)) begin bad++; $display("FAIL mul_rw k=%0d: got %b want %b", k, RW_1, (k == LAT + 1)); end
            if (k == LAT + 1) begin
                total++; if ({MD_1, DA_1} !== {2'b11, 5'd6}) begin bad++; $display("FAIL mul_port: got %b_%0d want 11_6", MD_1, DA_1); end
                total++; if (D_DATA !== 64'h1_FFFFFFFE) begin bad++; $display("FAIL mul_data: got %0h want 1fffffffe", D_DATA); end
            end
            advance();
        end
        total++; if (busy_cnt != LAT) begin bad++; $display("FAIL mul_busy_len: got %0d want %0d", busy_cnt, LAT); end
    endtask

    task automatic test_collision();
        logic [31:0] d = $urandom;
        alu_valid = 1'b1; alu_da = 5'd9; alu_data = d;
        mul_start = 1'b1; mul_da = 5'd12; mul_a = 32'd1000; mul_b = 32'd3000;
        settle();
        total++; if (alu_stall !== 1'b0) begin bad++; $display("FAIL coll_stall_start: got %b want 0", alu_stall); end
        advance();
        mul_start = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            if (k == LAT + 2) alu_valid = 1'b0;
            settle();
            total++; if (alu_stall !== (k == LAT)) begin bad++; $display("FAIL coll_stall k=%0d: got %b want %b", k, alu_stall, (k == LAT)); end
            if (k == LAT + 1) begin
                total++; if ({RW_1, MD_1, DA_1} !== {1'b1, 2'b11, 5'd12}) begin bad++; $display("FAIL coll_mul: got %b_%b_%0d want 1_11_12", RW_1, MD_1, DA_1); end
                total++; if (D_DATA !== 64'd3000000) begin bad++; $display("FAIL coll_mul_data: got %0d want 3000000", D_DATA); end
            end else begin
                total++; if ({RW_1, MD_1, DA_1} !== {1'b1, 2'b00, 5'd9}) begin bad++; $display("FAIL coll_alu k=%0d: got %b_%b_%0d want 1_00_9", k, RW_1, MD_1, DA_1); end
                total++; if (D_DATA !== {32'd0, d}) begin bad++; $display("FAIL coll_alu_data k=%0d: got %0h want %0h", k, D_DATA, d); end
            end
            advance();
        end
    endtask

    task automatic test_scoreboard();
        mul_start = 1'b1; mul_da = 5'd10; mul_a = 32'd5; mul_b = 32'd7; aa = 5'd11; ba = 5'd0;
        for (int k = 0; k <= LAT + 1; k++) begin
            settle();
            total++; if (hazard !== (SB_EN && (k >= 1) && (k <= LAT))) begin bad++; $display("FAIL sb_hazard k=%0d: got %b want %b", k, hazard, (SB_EN && (k >= 1) && (k <= LAT))); end
            advance();
            mul_start = 1'b0;
        end
        aa = 5'd0;
    endtask

    task automatic test_edges();
        logic [31:0] a = $urandom | 32'h8000_0000;
        logic [31:0] b = $urandom | 32'h8000_0000;
        logic [63:0] p = 64'(a) * 64'(b);
        // multiply to R31: low word only; R0 never flagged
        mul_start = 1'b1; mul_da = 5'd31; mul_a = a; mul_b = b; ba = 5'd0;
        settle(); advance();
        mul_start = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            aa = k[0] ? 5'd31 : 5'd0;
            settle();
            if (k <= LAT) begin
                total++; if (hazard !== (SB_EN && k[0])) begin bad++; $display("FAIL r31_hazard k=%0d: got %b want %b", k, hazard, (SB_EN && k[0])); end
            end else begin
                total++; if ({RW_1, MD_1, DA_1} !== {1'b1, 2'b00, 5'd31}) begin bad++; $display("FAIL r31_port: got %b_%b_%0d want 1_00_31", RW_1, MD_1, DA_1); end
                total++; if (D_DATA !== {32'd0, p[31:0]}) begin bad++; $display("FAIL r31_data: got %0h want %0h", D_DATA, {32'd0, p[31:0]}); end
            end
            advance();
        end
        aa = 5'd0;
        // second start while busy is dropped
        mul_start = 1'b1; mul_da = 5'd3; mul_a = 32'd11; mul_b = 32'd13;
        settle(); advance();
        mul_a = 32'd99; mul_b = 32'd99; mul_da = 5'd20;
        settle(); advance();
        mul_start = 1'b0;
        for (int k = 2; k <= LAT + 1; k++) begin
            settle();
            if (k == LAT + 1) begin
                total++; if ({RW_1, DA_1, D_DATA} !== {1'b1, 5'd3, 64'd143}) begin bad++; $display("FAIL busy_ignore: got %b_%0d_%0d want 1_3_143", RW_1, DA_1, D_DATA); end
            end
            advance();
        end
        // reset while BUSY aborts the multiply
        mul_start = 1'b1; mul_da = 5'd4;
        settle(); advance();
        mul_start = 1'b0;
        settle(); advance();
        rst = 1'b1;
        settle(); advance();
        rst = 1'b0;
        for (int k = 0; k <= LAT + 1; k++) begin
            settle();
            total++; if ({RW_1, mul_busy} !== 2'b00) begin bad++; $display("FAIL rst_busy k=%0d: got %b want 00", k, {RW_1, mul_busy}); end
            advance();
        end
    endtask

    task automatic test_random();
        bit last_stall = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(63) == 0);
            if (!last_stall) begin
                alu_valid = $urandom_range(1);
                alu_da    = 5'($urandom);
                alu_data  = $urandom;
            end
            mul_start = ($urandom_range(3) == 0);
            mul_da    = 5'($urandom);
            mul_a     = $urandom;
            mul_b     = $urandom;
            aa = $urandom_range(1) ? m_da + 5'($urandom_range(1)) : 5'($urandom);
            ba = 5'($urandom);
            settle();
            last_stall = e_stall && !rst;
            total++; if ({mul_busy, alu_stall, hazard} !== {e_busy, e_stall, e_haz}) begin bad++; $display("FAIL rnd_status c=%0d: got %b want %b", cyc, {mul_busy, alu_stall, hazard}, {e_busy, e_stall, e_haz}); end
            total++; if ({RW_1, MD_1, DA_1} !== {e_rw, e_md, e_da}) begin bad++; $display("FAIL rnd_port c=%0d: got %b_%b_%0d want %b_%b_%0d", cyc, RW_1, MD_1, DA_1, e_rw, e_md, e_da); end
            total++; if (D_DATA !== e_data) begin bad++; $display("FAIL rnd_data c=%0d: got %0h want %0h", cyc, D_DATA, e_data); end
            advance();
        end
        rst = 1'b0; alu_valid = 1'b0; mul_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_collision();
        test_scoreboard();
        test_edges();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
